// File: rtl/snn_pkg.sv
// Shared types and constants for the image column streamer.
package snn_pkg;

  localparam int JTAG_WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } state_t;

  // Counter width that stays legal when the count range collapses to one value.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/image_column_streamer_next_edge_sync.sv
// Two-flop synchroniser for the JTAG "next" level plus a one-cycle rising-edge pulse.
module next_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  // Clearing prev_q on reset lets a level already high after reset count as an edge.
  assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/image_column_streamer.sv
// Loads a WIDTH x HEIGHT bit image from JTAG words, then streams it column by column.
// Optional IMG_REPEAT_EN presents the image REPEATS times back-to-back per run.
//
// state  | meaning
// IDLE   | waiting for the first word of an image
// LOAD   | collecting further words until last or the buffer is full
// STREAM | presenting one column per cycle to the network
module image_column_streamer
  import snn_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int HEIGHT  = 7,
  parameter int REPEATS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [JTAG_WORD_W-1:0] data_word,
  input  logic                   next,
  input  logic                   last,
  output logic [HEIGHT-1:0]      pixels,
  output logic                   pix_valid,
  output logic                   start,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int NBITS  = WIDTH * HEIGHT;
  localparam int NWORDS = (NBITS + JTAG_WORD_W - 1) / JTAG_WORD_W;
  localparam int CW     = clog2_min1(WIDTH);
  localparam int IW     = clog2_min1(NWORDS + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NWORDS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    col_q;
  logic [NBITS-1:0] img_q;
  logic             done_q;
  logic             err_q;
  logic             next_rise;
  logic             first_pass;
  logic             run_end;

  next_edge_sync u_next_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (next),
    .rise     (next_rise)
  );

`ifdef IMG_REPEAT_EN
  localparam int            RW       = clog2_min1(REPEATS);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEATS - 1);

  logic [RW-1:0] rep_q;

  assign first_pass = (rep_q == '0);
  assign run_end    = (col_q == COL_LAST) && (rep_q == REP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_q <= '0;
    end else if (state_q == STREAM && col_q == COL_LAST) begin
      rep_q <= run_end ? '0 : rep_q + 1'b1;
    end
  end
`else
  // REPEATS has no effect when only a single presentation is built.
  logic unused_repeats;
  assign unused_repeats = (REPEATS > 0);
  assign first_pass     = 1'b1;
  assign run_end        = (col_q == COL_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (next_rise) begin
          state_d = (last || NWORDS == 1) ? STREAM : LOAD;
        end
      end
      LOAD: begin
        if (next_rise && (last || idx_q == IDX_LAST)) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (run_end) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bits beyond NBITS in the final word have no home in the buffer and drop out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= '0;
      idx_q <= '0;
    end else if (next_rise && state_q == IDLE) begin
      for (int k = 0; k < NBITS; k++) begin
        img_q[k] <= (k < JTAG_WORD_W) ? data_word[k % JTAG_WORD_W] : 1'b0;
      end
      idx_q <= IW'(1);
    end else if (next_rise && state_q == LOAD) begin
      for (int k = 0; k < NBITS; k++) begin
        if (IW'(k / JTAG_WORD_W) == idx_q) begin
          img_q[k] <= data_word[k % JTAG_WORD_W];
        end
      end
      idx_q <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == STREAM) begin
        col_q <= (col_q == COL_LAST) ? '0 : col_q + 1'b1;
      end
      done_q <= (state_q == STREAM) && run_end;
      if (state_q == STREAM && next_rise) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    ready     = (state_q == IDLE) || (state_q == LOAD);
    busy      = (state_q == STREAM);
    pix_valid = (state_q == STREAM);
    start     = (state_q == STREAM) && (col_q == '0) && first_pass;
    pixels    = '0;
    if (pix_valid) begin
      pixels = img_q[int'(col_q) * HEIGHT +: HEIGHT];
    end
  end

  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_image_column_streamer.sv
// Directed self-checking bench for image_column_streamer at default parameters.
module tb_image_column_streamer;

`ifdef IMG_REPEAT_EN
  localparam int NREP = 4;
`else
  localparam int NREP = 1;
`endif

  typedef logic [6:0] col_arr_t [8];

  logic        clk;
  logic        rst_n;
  logic [31:0] data_word;
  logic        next;
  logic        last;
  logic [6:0]  pixels;
  logic        pix_valid;
  logic        start;
  logic        ready;
  logic        busy;
  logic        done;
  logic        err;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // 0x00FEDCBA_89ABCDEF split into 7-bit columns, LSB first
  col_arr_t cols_two  = '{7'h6F, 7'h1B, 7'h2F, 7'h4D, 7'h28, 7'h17, 7'h37, 7'h7F};
  col_arr_t cols_ones = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0F, 7'h00, 7'h00, 7'h00};
  col_arr_t cols_held = '{7'h78, 7'h2C, 7'h51, 7'h11, 7'h01, 7'h00, 7'h00, 7'h00};

  image_column_streamer #(
    .WIDTH   (8),
    .HEIGHT  (7),
    .REPEATS (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_word (data_word),
    .next      (next),
    .last      (last),
    .pixels    (pixels),
    .pix_valid (pix_valid),
    .start     (start),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Raise next with a word; the word lands on the third clock edge.
  task automatic send_word(input logic [31:0] word, input logic is_last);
    data_word = word;
    last      = is_last;
    next      = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    next = 1'b0;
  endtask

  task automatic gap();
    repeat (2) tick();
  endtask

  task automatic check_stream(input string tag, input col_arr_t cols, input int inj_col,
                              input int stop_col, input logic exp_err);
    for (int r = 0; r < NREP; r++) begin
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_pix"}, 32'(pixels), 32'(cols[c]));
        chk({tag, "_start"}, 32'(start), (r == 0 && c == 0) ? 32'd1 : 32'd0);
        if (r == 0 && c == inj_col) next = 1'b1;
        if (r == 0 && c == stop_col) return;
      end
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_done_pix"}, 32'(pixels), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    next      = 1'b0;
    last      = 1'b0;
    data_word = 32'h0;
    #2;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_pix", 32'(pixels), 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    rst_n = 1'b1;
    gap();

    // two words, last on the second
    send_word(32'h89AB_CDEF, 1'b0);
    chk("two_load_ready", 32'(ready), 32'd1);
    chk("two_load_busy", 32'(busy), 32'd0);
    gap();
    send_word(32'h00FE_DCBA, 1'b1);
    check_stream("two", cols_two, -1, -1, 1'b0);
    gap();

    // single all-ones word ends the image early; the rest reads as zero
    send_word(32'hFFFF_FFFF, 1'b1);
    check_stream("ones", cols_ones, -1, -1, 1'b0);
    gap();

    // next held high for 20 cycles captures exactly once
    data_word = 32'h1234_5678;
    last      = 1'b0;
    next      = 1'b1;
    repeat (20) tick();
    chk("held_ready", 32'(ready), 32'd1);
    chk("held_busy", 32'(busy), 32'd0);
    next = 1'b0;
    gap();
    send_word(32'h0000_0000, 1'b1);
    check_stream("held", cols_held, -1, -1, 1'b0);
    gap();

    // next edge during column 3: stream unchanged, err sticky
    send_word(32'h89AB_CDEF, 1'b0);
    gap();
    send_word(32'h00FE_DCBA, 1'b1);
    check_stream("inj", cols_two, 3, -1, 1'b1);
    next = 1'b0;
    gap();
    chk("inj_err_sticky", 32'(err), 32'd1);
    chk("inj_no_capture", 32'(busy), 32'd0);

    // reset during column 5, then load with next already high at release
    send_word(32'h89AB_CDEF, 1'b0);
    gap();
    send_word(32'h00FE_DCBA, 1'b1);
    check_stream("pre_rst", cols_two, -1, 5, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(pix_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_ready", 32'(ready), 32'd1);
    chk("arst_pix", 32'(pixels), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    data_word = 32'hFFFF_FFFF;
    last      = 1'b1;
    next      = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_done", 32'(done), 32'd0);
    end
    tick();
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    next = 1'b0;
    check_stream("post_rst", cols_ones, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
